reg_move_unit: RTL and testbench
================================

# reg_move_unit

Parametrised register bank with a built-in transfer engine for the z0 CPU datapath. It generalises the fixed X/Y/MAR/MDR move path to NREGS registers of WIDTH bits and supports MOV, two-cycle SWAP and CLR instructions through a valid/ready handshake. An external write port lets the memory and ALU stages load registers. The block sits between instruction decode and the datapath registers and owns their storage.

## Interface
- WIDTH, 16, register width in bits
- NREGS, 4, number of registers (index 0=MDR, 1=MAR, 2=Y, 3=X at default); legal range 2..16
- IDXW, 2, index width; must equal clog2(NREGS)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  engine can accept this cycle (combinational)
- instruction  in  16  [15:8] opcode, [7:4] dst index, [3:0] src index
- ext_we  in  1  external write enable
- ext_idx  in  IDXW  external write target
- ext_data  in  WIDTH  external write data
- rd_idx  in  IDXW  read-port select
- rd_data  out  WIDTH  reg[rd_idx] (combinational); 0 if rd_idx >= NREGS
- regs_flat  out  NREGS*WIDTH  all registers, reg[i] at bits [i*WIDTH +: WIDTH]
- busy  out  1  engine not in IDLE
- done  out  1  one-cycle pulse: instruction completed
- err  out  1  one-cycle pulse: instruction rejected for an illegal index

## Operation
- Opcodes: 8'h01 MOV (reg[dst] <= reg[src]), 8'h02 SWAP, 8'h03 CLR (reg[dst] <= 0; src is ignored). Any other opcode is accepted and ignored: no write, no done, no err.
- A field value >= NREGS is illegal; only MOV/SWAP check src. An illegal instruction is accepted, writes nothing, and pulses err instead of done.
- The bank has a single write port and takes at most one register write per cycle. ext_we has priority over the engine.
- FSM states: IDLE and SWAP2.
- instr_ready = (state==IDLE) && !ext_we.
- Accept occurs when instr_valid && instr_ready.
- IDLE, accept MOV/CLR: write on the same edge; stay in IDLE.
- IDLE, accept SWAP: tmp <= reg[dst], reg[dst] <= reg[src]; go to SWAP2.
- SWAP2 with !ext_we: reg[src] <= tmp; go to IDLE.
- SWAP2 with ext_we: hold (the completion write is deferred, the ext write proceeds). If ext_idx equals dst or src, the ext value is overwritten by the SWAP completion for src only; the ext write to dst stands.
- ext_we with ext_idx >= NREGS is ignored.
- MOV with dst==src completes normally and leaves the value unchanged. SWAP with dst==src takes 2 cycles and leaves the value unchanged.

## Timing
- Reset values: all registers 0, tmp 0, state IDLE, done 0, err 0, busy 0. instr_ready is 1 unless ext_we is high.
- Reset mid-SWAP aborts the instruction: no done, and all registers return to 0.
- MOV/CLR: the write is visible on rd_data/regs_flat the cycle after the accept edge, and done pulses in that same cycle.
- SWAP: both registers are final one cycle after the SWAP2 completion edge, and done pulses then. Minimum latency is 2 cycles from accept. busy is high for the cycle(s) in SWAP2.
- done and err are registered and never both high. Back-to-back MOVs sustain 1 instruction per cycle.
- ext write data is visible the cycle after ext_we.

## Test plan
- Reset, then ext-load X=16'h1234 and Y=16'hABCD; MOV Y,X (16'h0123) → next cycle Y=16'h1234, done=1 for one cycle, X unchanged.
- With MDR=16'h00AA and MAR=16'h5500, SWAP MDR,MAR (16'h0201) → instr_ready=0 and busy=1 for 1 cycle; then MDR=16'h5500, MAR=16'h00AA, single done pulse.
- SWAP accepted while ext_we=1 to X is held in SWAP2 for 3 cycles → completion deferred by 3 cycles; X takes the ext value; swap result is correct.
- NREGS=4, MOV with src=4'h7 → err pulse, no done, no register change. Opcode 8'h55 → no write, no done, no err.
- Four back-to-back MOVs with instr_valid held high → four consecutive done pulses and final values match a reference model. Also assert ext_we on one cycle → instr_ready=0 that cycle and the stream stalls exactly 1 cycle.
- Assert rst in the SWAP2 cycle → all regs 0, no done, state IDLE. Parameter sweep with WIDTH=32, NREGS=8: random MOV/SWAP/CLR/ext stream versus the model.

Source files
------------

// File: rtl/reg_move_unit.sv
// Register bank with a MOV/SWAP/CLR transfer engine and an external write port.
// One write per cycle; the external port always wins over the engine.
module reg_move_unit #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int IDXW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [15:0]            instruction,
  input  logic                   ext_we,
  input  logic [IDXW-1:0]        ext_idx,
  input  logic [WIDTH-1:0]       ext_data,
  input  logic [IDXW-1:0]        rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SWAP2 = 1'b1;
  localparam logic [7:0]      OP_MOV   = 8'h01;
  localparam logic [7:0]      OP_SWAP  = 8'h02;
  localparam logic [7:0]      OP_CLR   = 8'h03;
  localparam logic [4:0]      NREGS_F  = 5'(NREGS);
  localparam logic [IDXW:0]   NREGS_I  = (IDXW+1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [IDXW-1:0]  swap_src_q, swap_src_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]       opcode;
  logic [3:0]       dst_f, src_f;
  logic [IDXW-1:0]  dst_i, src_i;
  logic             dst_ok, src_ok, ext_ok, accept;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign opcode = instruction[15:8];
  assign dst_f  = instruction[7:4];
  assign src_f  = instruction[3:0];
  assign dst_i  = dst_f[IDXW-1:0];
  assign src_i  = src_f[IDXW-1:0];
  assign dst_ok = {1'b0, dst_f} < NREGS_F;
  assign src_ok = {1'b0, src_f} < NREGS_F;
  assign ext_ok = {1'b0, ext_idx} < NREGS_I;

  assign instr_ready = (state_q == ST_IDLE) && !ext_we;
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign rd_data     = ({1'b0, rd_idx} < NREGS_I) ? regs_q[rd_idx] : '0;

  // accept already excludes ext_we, so the engine and the external port never collide
  always_comb begin
    state_d    = state_q;
    tmp_d      = tmp_q;
    swap_src_d = swap_src_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en      = ext_we && ext_ok;
    wr_idx     = ext_idx;
    wr_data    = ext_data;
    if (state_q == ST_SWAP2) begin
      if (!ext_we) begin
        wr_en   = 1'b1;
        wr_idx  = swap_src_q;
        wr_data = tmp_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      case (opcode)
        OP_MOV: begin
          if (dst_ok && src_ok) begin
            wr_en   = 1'b1;
            wr_idx  = dst_i;
            wr_data = regs_q[src_i];
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SWAP: begin
          if (dst_ok && src_ok) begin
            wr_en      = 1'b1;
            wr_idx     = dst_i;
            wr_data    = regs_q[src_i];
            tmp_d      = regs_q[dst_i];
            swap_src_d = src_i;
            state_d    = ST_SWAP2;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLR: begin
          if (dst_ok) begin
            wr_en   = 1'b1;
            wr_idx  = dst_i;
            wr_data = '0;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmp_q      <= '0;
      swap_src_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmp_q      <= tmp_d;
      swap_src_q <= swap_src_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign regs_flat[gi*WIDTH +: WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_reg_move_unit.sv
// Scoreboard bench for reg_move_unit: a 16x4 instance for directed cases and a
// 32x8 instance for a random MOV/SWAP/CLR/ext stream, both against one model.
module tb_reg_move_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instruction;
  logic        ext_we;
  logic [2:0]  ext_idx;
  logic [31:0] ext_data;
  logic [2:0]  rd_idx;

  logic        rdy4, busy4, done4, err4;
  logic [15:0] rd4;
  logic [63:0] flat4;
  logic        rdy8, busy8, done8, err8;
  logic [31:0] rd8;
  logic [255:0] flat8;

  always #5 clk = ~clk;

  reg_move_unit #(.WIDTH(16), .NREGS(4), .IDXW(2)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy4),
    .instruction(instruction), .ext_we(ext_we), .ext_idx(ext_idx[1:0]),
    .ext_data(ext_data[15:0]), .rd_idx(rd_idx[1:0]), .rd_data(rd4),
    .regs_flat(flat4), .busy(busy4), .done(done4), .err(err4)
  );

  reg_move_unit #(.WIDTH(32), .NREGS(8), .IDXW(3)) dut8 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy8),
    .instruction(instruction), .ext_we(ext_we), .ext_idx(ext_idx),
    .ext_data(ext_data), .rd_idx(rd_idx), .rd_data(rd8),
    .regs_flat(flat8), .busy(busy8), .done(done8), .err(err8)
  );

  typedef struct {
    bit          is_err;
    int          dst;
    int          src;
    logic [31:0] dv;
    logic [31:0] sv;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sel;
  int          nr;
  logic [31:0] wmask;
  logic [31:0] m_regs[16];
  logic [31:0] m_tmp;
  bit          m_swap2;
  int          m_dst, m_src;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int i);
    return sel ? flat8[i*32 +: 32] : {16'h0, flat4[i*16 +: 16]};
  endfunction

  function automatic logic o_ready(); return sel ? rdy8 : rdy4; endfunction
  function automatic logic o_busy();  return sel ? busy8 : busy4; endfunction
  function automatic logic o_done();  return sel ? done8 : done4; endfunction
  function automatic logic o_err();   return sel ? err8 : err4; endfunction
  function automatic logic [31:0] o_rd(); return sel ? rd8 : {16'h0, rd4}; endfunction

  function automatic void push_exp(input bit is_err, input int d, input int s);
    exp_t e;
    e.is_err = is_err;
    e.dst = d;
    e.src = s;
    e.dv = is_err ? 32'h0 : m_regs[d];
    e.sv = is_err ? 32'h0 : m_regs[s];
    sb.push_back(e);
  endfunction

  // Behaviour at one rising edge, from the instruction set's point of view
  task automatic model_step(input bit v, input logic [15:0] ins, input bit we,
                            input int eidx, input logic [31:0] edata, output bit acc);
    int d, s;
    logic [7:0] op;
    acc = v && !m_swap2 && !we;
    d = int'(ins[7:4]);
    s = int'(ins[3:0]);
    op = ins[15:8];
    if (we && eidx < nr) m_regs[eidx] = edata & wmask;
    if (m_swap2 && !we) begin
      m_regs[m_src] = m_tmp;
      m_swap2 = 1'b0;
      push_exp(1'b0, m_dst, m_src);
    end else if (acc) begin
      case (op)
        8'h01: if (d < nr && s < nr) begin
                 m_regs[d] = m_regs[s];
                 push_exp(1'b0, d, s);
               end else push_exp(1'b1, 0, 0);
        8'h02: if (d < nr && s < nr) begin
                 m_tmp = m_regs[d];
                 m_regs[d] = m_regs[s];
                 m_dst = d;
                 m_src = s;
                 m_swap2 = 1'b1;
               end else push_exp(1'b1, 0, 0);
        8'h03: if (d < nr) begin
                 m_regs[d] = 32'h0;
                 push_exp(1'b0, d, d);
               end else push_exp(1'b1, 0, 0);
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] ins, input bit we,
                     input logic [2:0] eidx, input logic [31:0] edata, output bit acc);
    exp_t e;
    @(negedge clk);
    instr_valid = v;
    instruction = ins;
    ext_we = we;
    ext_idx = eidx;
    ext_data = edata;
    #1;
    check_eq("instr_ready", 32'(o_ready()), 32'(!m_swap2 && !we));
    model_step(v, ins, we, int'(eidx), edata, acc);
    @(posedge clk);
    #1;
    check_eq("busy", 32'(o_busy()), 32'(m_swap2));
    if (o_done() && o_err()) check_eq("done_err_excl", 32'h1, 32'h0);
    if (o_done() || o_err()) begin
      if (sb.size() == 0) begin
        check_eq("spurious_pulse", {30'h0, o_done(), o_err()}, 32'h0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_is_err", 32'(o_err()), 32'(e.is_err));
        if (!e.is_err) begin
          check_eq($sformatf("dst_r%0d", e.dst), get_reg(e.dst), e.dv);
          check_eq($sformatf("src_r%0d", e.src), get_reg(e.src), e.sv);
        end
      end
    end else if (sb.size() != 0) begin
      check_eq("missing_pulse", 32'h0, 32'h1);
      sb.delete();
    end
  endtask

  // Only called with the engine idle: the extra edge it may span carries no work
  task automatic check_all();
    instr_valid = 1'b0;
    ext_we = 1'b0;
    for (int i = 0; i < nr; i++) begin
      check_eq($sformatf("flat_r%0d", i), get_reg(i), m_regs[i]);
      rd_idx = 3'(i);
      #1;
      check_eq($sformatf("rd_r%0d", i), o_rd(), m_regs[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    ext_we = 1'b0;
    instruction = 16'h0;
    m_swap2 = 1'b0;
    m_tmp = 32'h0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] stream[4] = '{16'h0123, 16'h0132, 16'h0102, 16'h0130};

  initial begin
    bit a;
    int cycles, nacc;
    logic [15:0] ins;
    logic [7:0] ops[4] = '{8'h01, 8'h02, 8'h03, 8'h7F};
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = 16'h0;
    ext_we = 1'b0;
    ext_idx = 3'h0;
    ext_data = 32'h0;
    rd_idx = 3'h0;
    sel = 1'b0;
    nr = 4;
    wmask = 32'h0000FFFF;
    do_reset();
    #1;
    check_eq("rst_ready", 32'(o_ready()), 32'h1);
    check_eq("rst_busy", 32'(o_busy()), 32'h0);
    check_eq("rst_done", 32'(o_done()), 32'h0);
    check_eq("rst_err", 32'(o_err()), 32'h0);
    check_all();

    // MOV Y,X
    cyc(0, 16'h0, 1, 3'd3, 32'h1234, a);
    cyc(0, 16'h0, 1, 3'd2, 32'hABCD, a);
    cyc(1, 16'h0123, 0, 3'd0, 32'h0, a);
    check_eq("mov_y", get_reg(2), 32'h1234);
    check_eq("mov_x", get_reg(3), 32'h1234);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_eq("done_one_cycle", 32'(o_done()), 32'h0);

    // SWAP MDR,MAR
    cyc(0, 16'h0, 1, 3'd0, 32'h00AA, a);
    cyc(0, 16'h0, 1, 3'd1, 32'h5500, a);
    cyc(1, 16'h0201, 0, 3'd0, 32'h0, a);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_eq("swap_mdr", get_reg(0), 32'h5500);
    check_eq("swap_mar", get_reg(1), 32'h00AA);

    // SWAP X,Y held by three ext writes to X
    cyc(0, 16'h0, 1, 3'd2, 32'hBEEF, a);
    cyc(1, 16'h0232, 0, 3'd0, 32'h0, a);
    cyc(0, 16'h0, 1, 3'd3, 32'h1111, a);
    cyc(0, 16'h0, 1, 3'd3, 32'h2222, a);
    cyc(0, 16'h0, 1, 3'd3, 32'h3333, a);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_eq("held_swap_x", get_reg(3), 32'h3333);
    check_eq("held_swap_y", get_reg(2), 32'h1234);

    // illegal index, unknown opcode, CLR
    cyc(1, 16'h0127, 0, 3'd0, 32'h0, a);
    cyc(1, 16'h5523, 0, 3'd0, 32'h0, a);
    cyc(1, 16'h0390, 0, 3'd0, 32'h0, a);
    cyc(1, 16'h033F, 0, 3'd0, 32'h0, a);
    check_eq("clr_x", get_reg(3), 32'h0);
    cyc(1, 16'h0111, 0, 3'd0, 32'h0, a);
    cyc(1, 16'h0222, 0, 3'd0, 32'h0, a);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_all();

    // back-to-back MOVs with one ext cycle stalling the stream
    cycles = 0;
    nacc = 0;
    while (nacc < 4 && cycles < 20) begin
      cyc(1, stream[nacc], cycles == 1, 3'd1, 32'h7777, a);
      if (a) nacc++;
      cycles++;
    end
    check_eq("stream_cycles", 32'(cycles), 32'd5);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_all();

    // reset during SWAP2
    cyc(1, 16'h0201, 0, 3'd0, 32'h0, a);
    do_reset();
    #1;
    check_eq("abort_busy", 32'(o_busy()), 32'h0);
    check_eq("abort_done", 32'(o_done()), 32'h0);
    check_all();
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 0, 3'd0, 32'h0, a);

    // random stream on the 32x8 instance
    sel = 1'b1;
    nr = 8;
    wmask = 32'hFFFFFFFF;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ins = {ops[$urandom_range(0, 3)], 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cyc($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) == 0,
          3'($urandom_range(0, 7)), $urandom, a);
    end
    for (int i = 0; i < 10 && m_swap2; i++) cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    cyc(0, 16'h0, 0, 3'd0, 32'h0, a);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
